// File: rtl/assign_pkg.sv
// Shared types for the job-assignment search: evaluator FSM states, default sizing,
// and a slot extractor for packed permutations (slot i = job assigned to worker i).
package assign_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEF_N     = 8;
    localparam int DEF_CW    = 7;
    localparam int DEF_TW    = 10;
    localparam int DEF_MCW   = 16;
    localparam int PERM_MAXW = 256;

    function automatic int unsigned slot_get(input logic [PERM_MAXW-1:0] p,
                                             input int unsigned idx,
                                             input int unsigned idw);
        logic [PERM_MAXW-1:0] sh;
        sh = (p >> (idx * idw)) & ((PERM_MAXW'(1) << idw) - PERM_MAXW'(1));
        return sh[31:0];
    endfunction

endpackage

// File: rtl/perm_slot_mux.sv
// Selects one IDW-wide slot out of a packed N-slot permutation; purely combinational.
module perm_slot_mux #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N*IDW-1:0] perm_dat,
    input  logic [IDW-1:0]   sel,
    output logic [IDW-1:0]   slot_dat
);

    always_comb begin
        slot_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IDW'(i)) slot_dat = perm_dat[i*IDW +: IDW];
        end
    end

endmodule

// File: rtl/assign_cost_eval.sv
// Cost evaluator: sums Cost over workers of each accepted permutation, tracks min/count/best.
// N+2 cycles per permutation (k+2 if pruned at worker k); perm_ready only in IDLE, input ignored otherwise.
module assign_cost_eval
    import assign_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N),
    parameter int CW  = DEF_CW,
    parameter int TW  = DEF_TW,
    parameter int MCW = DEF_MCW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               perm_valid,
    input  logic [N*IDW-1:0]   perm,
    input  logic               perm_last,
    output logic               perm_ready,
    input  logic               prune_en,
    output logic [IDW-1:0]     W,
    output logic [IDW-1:0]     J,
    input  logic [CW-1:0]      Cost,
    output logic [TW-1:0]      MinCost,
    output logic [MCW-1:0]     MatchCount,
    output logic [N*IDW-1:0]   BestPerm,
    output logic               Valid
);

    localparam logic [IDW-1:0] W_LAST = IDW'(N - 1);

    state_e             state_q, state_d;
    logic [IDW-1:0]     w_q, w_d;
    logic [TW-1:0]      total_q, total_d;
    logic [N*IDW-1:0]   perm_q, perm_d;
    logic               last_q, last_d;
    logic [TW-1:0]      min_q, min_d;
    logic [MCW-1:0]     cnt_q, cnt_d;
    logic [N*IDW-1:0]   best_q, best_d;
    logic               fresh_q, fresh_d;

    logic [TW-1:0]      acc_sum;
    state_e             end_state;

    perm_slot_mux #(.N(N), .IDW(IDW)) u_slot_mux (
        .perm_dat (perm_q),
        .sel      (w_q),
        .slot_dat (J)
    );

    assign acc_sum   = total_q + TW'(Cost);
    assign end_state = last_q ? ST_DONE : ST_IDLE;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        total_d = total_q;
        perm_d  = perm_q;
        last_d  = last_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        fresh_d = fresh_q;
        case (state_q)
            ST_IDLE: begin
                w_d     = '0;
                total_d = '0;
                if (perm_valid) begin
                    perm_d  = perm;
                    last_d  = perm_last;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                // Strictly worse partial sums can never tie the minimum, so abort them.
                if (prune_en && !fresh_q && (acc_sum > min_q)) begin
                    w_d     = '0;
                    state_d = end_state;
                end else begin
                    total_d = acc_sum;
                    if (w_q == W_LAST) state_d = ST_CMP;
                    else               w_d = w_q + 1'b1;
                end
            end
            ST_CMP: begin
                if (fresh_q || (total_q < min_q)) begin
                    min_d   = total_q;
                    cnt_d   = MCW'(1);
                    best_d  = perm_q;
                    fresh_d = 1'b0;
                end else if (total_q == min_q) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
                state_d = end_state;
            end
            ST_DONE: begin
                fresh_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            total_q <= '0;
            perm_q  <= '0;
            last_q  <= 1'b0;
            min_q   <= '1;
            cnt_q   <= '0;
            best_q  <= '0;
            fresh_q <= 1'b1;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            total_q <= total_d;
            perm_q  <= perm_d;
            last_q  <= last_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            fresh_q <= fresh_d;
        end
    end

    assign perm_ready = (state_q == ST_IDLE);
    assign Valid      = (state_q == ST_DONE);
    assign W          = w_q;
    assign MinCost    = min_q;
    assign MatchCount = cnt_q;
    assign BestPerm   = best_q;

endmodule

// File: tb/tb_assign_cost_eval.sv
// Randomized scoreboard bench for assign_cost_eval: drivers push expected search results,
// a negedge monitor pops them on every Valid pulse.
module tb_assign_cost_eval;
    import assign_pkg::*;

    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int CW  = 7;
    localparam int TW  = 10;
    localparam int MCW = 16;
    localparam int PW  = N * IDW;

    logic            clk = 1'b0;
    logic            reset;
    logic            perm_valid;
    logic [PW-1:0]   perm;
    logic            perm_last;
    logic            perm_ready;
    logic            prune_en;
    logic [IDW-1:0]  W;
    logic [IDW-1:0]  J;
    logic [CW-1:0]   Cost;
    logic [TW-1:0]   MinCost;
    logic [MCW-1:0]  MatchCount;
    logic [PW-1:0]   BestPerm;
    logic            Valid;

    always #5 clk = ~clk;

    assign_cost_eval #(.N(N), .IDW(IDW), .CW(CW), .TW(TW), .MCW(MCW)) dut (
        .clk        (clk),
        .reset      (reset),
        .perm_valid (perm_valid),
        .perm       (perm),
        .perm_last  (perm_last),
        .perm_ready (perm_ready),
        .prune_en   (prune_en),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MinCost    (MinCost),
        .MatchCount (MatchCount),
        .BestPerm   (BestPerm),
        .Valid      (Valid)
    );

    // Cost table: 0 = W+J, 1 = diagonal-free (0 on diagonal, else 10), 2 = random table.
    int             mode = 0;
    logic [CW-1:0]  tab [N][N];

    assign Cost = (mode == 0) ? ({4'd0, W} + {4'd0, J}) :
                  (mode == 1) ? ((W == J) ? 7'd0 : 7'd10) : tab[W][J];

    function automatic int cost_of(int w, int j);
        if (mode == 0) return w + j;
        if (mode == 1) return (w == j) ? 0 : 10;
        return int'(tab[w][j]);
    endfunction

    typedef struct {
        int            min;
        int            cnt;
        logic [PW-1:0] best;
        int            lat;
        int            cyc;
    } exp_t;

    exp_t           sb [$];
    logic [PW-1:0]  sq [$];
    int             prune_k [$];
    int             total = 0;
    int             bad = 0;
    int             cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [PW-1:0] pack(input int a [N]);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*IDW +: IDW] = IDW'(a[i]);
        return r;
    endfunction

    function automatic logic [PW-1:0] rand_perm();
        int a [N];
        for (int i = 0; i < N; i++) a[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = a[i]; a[i] = a[j]; a[j] = t;
        end
        return pack(a);
    endfunction

    function automatic logic [PW-1:0] ident_perm(input bit rev);
        int a [N];
        for (int i = 0; i < N; i++) a[i] = rev ? (N - 1 - i) : i;
        return pack(a);
    endfunction

    // Reference: totals from the table, running min/count/first-best, prune on prefix sum > min.
    task automatic run_model(input bit prn, output exp_t e);
        bit            fresh;
        int            mn;
        int            ct;
        logic [PW-1:0] bp;
        fresh = 1; mn = 0; ct = 0; bp = '0;
        e.lat = N + 2;
        prune_k.delete();
        foreach (sq[p]) begin
            int sum;
            int k;
            sum = 0; k = -1;
            for (int i = 0; i < N; i++) begin
                sum += cost_of(i, int'(slot_get(PERM_MAXW'(sq[p]), i, IDW)));
                if (prn && !fresh && k < 0 && sum > mn) k = i;
            end
            prune_k.push_back(k);
            if (k < 0) begin
                if (fresh || sum < mn) begin
                    mn = sum; ct = 1; bp = sq[p]; fresh = 0;
                end else if (sum == mn) begin
                    ct++;
                end
            end
            if (p == sq.size() - 1) e.lat = (k < 0) ? N + 2 : k + 2;
        end
        e.min = mn; e.cnt = ct; e.best = bp; e.cyc = 0;
    endtask

    // Junk on perm/perm_last (and perm_valid if junk) whenever perm_ready is low.
    task automatic run_search(input bit prn, input bit junk);
        exp_t          e;
        logic [PW-1:0] cur;
        int            idx, acc, kcur, guard;
        idx = 0; acc = -1; kcur = -1; guard = 0; cur = '0;
        run_model(prn, e);
        prune_en = prn;
        while ((idx < sq.size() || acc >= 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (acc >= 0) begin
                chk("acc_W", W, acc);
                chk("acc_J", J, slot_get(PERM_MAXW'(cur), acc, IDW));
                acc = (acc == N - 1 || acc == kcur) ? -1 : acc + 1;
            end
            if (perm_ready && idx < sq.size()) begin
                perm_valid = 1'b1;
                perm       = sq[idx];
                perm_last  = (idx == sq.size() - 1);
                cur  = sq[idx];
                kcur = prune_k[idx];
                acc  = 0;
                if (perm_last) begin
                    e.cyc = cyc + e.lat;
                    sb.push_back(e);
                end
                idx++;
            end else begin
                perm_valid = junk;
                perm       = PW'($urandom);
                perm_last  = $urandom_range(1, 0) == 1;
            end
        end
        perm_valid = 1'b0;
        if (guard >= 2000) chk("search_timeout", guard, 0);
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("valid_seen", sb.size(), 0);
        @(negedge clk);
        chk("persist_min", MinCost, e.min);
        chk("persist_cnt", MatchCount, e.cnt);
        chk("idle_ready", perm_ready, 1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, perm_ready, 1);
        chk({tag, "_valid"}, Valid, 0);
        chk({tag, "_min"}, MinCost, 1023);
        chk({tag, "_cnt"}, MatchCount, 0);
        chk({tag, "_best"}, BestPerm, 0);
    endtask

    task automatic reset_mid();
        logic [PW-1:0] p [3];
        int idx, acc, guard;
        bit hit;
        idx = 0; acc = -1; guard = 0; hit = 0;
        mode = 0; prune_en = 1'b0;
        for (int i = 0; i < 3; i++) p[i] = rand_perm();
        while (!hit && guard < 200) begin
            @(negedge clk);
            guard++;
            if (acc >= 0) begin
                if (idx == 2 && acc == 4) begin
                    chk("rst_at_w4", W, 4);
                    hit = 1;
                end
                acc = (acc == N - 1) ? -1 : acc + 1;
            end
            if (!hit && perm_ready && idx < 3) begin
                perm_valid = 1'b1; perm = p[idx]; perm_last = 1'b0;
                acc = 0; idx++;
            end
        end
        if (!hit) chk("rst_reach_w4", 0, 1);
        chk("pre_rst_min", MinCost, 56);
        reset = 1'b1; perm_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("midrst");
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (Valid && perm_ready) chk("valid_with_ready", 1, 0);
            if (Valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("min_cost", MinCost, e.min);
                    chk("match_count", MatchCount, e.cnt);
                    chk("best_perm", BestPerm, e.best);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; perm_valid = 1'b0; perm = '0; perm_last = 1'b0; prune_en = 1'b0;
        for (int w = 0; w < N; w++)
            for (int j = 0; j < N; j++) tab[w][j] = CW'($urandom_range(127, 0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        // Every permutation totals 56 under W+J.
        mode = 0;
        sq.delete(); sq.push_back(rand_perm()); sq.push_back(rand_perm()); sq.push_back(ident_perm(1));
        run_search(0, 1);
        chk("tp1_min", MinCost, 56);
        chk("tp1_cnt", MatchCount, 3);
        chk("tp1_best", BestPerm, sq[0]);

        mode = 1;
        sq.delete(); sq.push_back(ident_perm(1)); sq.push_back(ident_perm(0));
        run_search(0, 1);
        chk("tp2_best", BestPerm, ident_perm(0));

        sq.delete(); sq.push_back(ident_perm(0)); sq.push_back(ident_perm(1));
        run_search(1, 0);
        chk("tp3_min", MinCost, 0);

        reset_mid();
        mode = 2;
        sq.delete(); sq.push_back(rand_perm());
        run_search(1, 1);

        // Second search's worse total must still overwrite stale statistics.
        mode = 1;
        sq.delete(); sq.push_back(ident_perm(0));
        run_search(0, 0);
        sq.delete(); sq.push_back(ident_perm(1));
        run_search(1, 0);
        chk("b2b_min", MinCost, 80);

        mode = 2;
        for (int s = 0; s < 8; s++) begin
            int n;
            n = int'($urandom_range(6, 1));
            sq.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3, 0) == 0 && i > 0) sq.push_back(sq[0]);
                else sq.push_back(rand_perm());
            end
            run_search($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
